// File: rtl/corr_add_serial_unit.sv
// corr_add_serial_unit: runtime-loadable correction table plus limb-serial adder.
// Returns (a_in + table[idx]) mod 2^WIDTH and the carry out of bit WIDTH-1.
`default_nettype none

module corr_add_serial_unit #(
  parameter int WIDTH  = 1506,
  parameter int IDX_W  = 4,
  parameter int LIMB_W = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [WIDTH-1:0] cfg_data,
  output logic             cfg_err,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [IDX_W-1:0] idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out
);

  localparam int NUM_LIMBS = (WIDTH + LIMB_W - 1) / LIMB_W;
  localparam int PAD_W     = NUM_LIMBS * LIMB_W;
  localparam int TOP_W     = WIDTH - (NUM_LIMBS - 1) * LIMB_W;
  localparam int DEPTH     = 1 << IDX_W;
  localparam int CNT_W     = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;
  localparam logic [CNT_W-1:0] LAST_LIMB = CNT_W'(NUM_LIMBS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] const_tbl [DEPTH];
  logic [PAD_W-1:0] op_sh;
  logic [PAD_W-1:0] cst_sh;
  logic [PAD_W-1:0] op_next;
  logic [LIMB_W:0]  limb_sum;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             alive;
  logic             accept;

  // Working limbs are zero-padded, so the top limb's carry out lands at bit TOP_W.
  assign limb_sum = {1'b0, op_sh[LIMB_W-1:0]} + {1'b0, cst_sh[LIMB_W-1:0]}
                  + (LIMB_W + 1)'(carry);

  // Result limbs shift in at the top as operand limbs shift out the bottom.
  generate
    if (NUM_LIMBS > 1) begin : g_multi_limb
      assign op_next = {limb_sum[LIMB_W-1:0], op_sh[PAD_W-1:LIMB_W]};
    end else begin : g_single_limb
      assign op_next = limb_sum[LIMB_W-1:0];
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = alive;
        accept   = alive & in_valid;
        if (accept) state_nxt = RUN;
      end
      RUN: begin
        if (cnt == LAST_LIMB) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < DEPTH; e++) const_tbl[e] <= '0;
      op_sh     <= '0;
      cst_sh    <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      alive     <= 1'b0;
      cfg_err   <= 1'b0;
      sum_out   <= '0;
      carry_out <= 1'b0;
    end else begin
      alive   <= 1'b1;
      cfg_err <= cfg_we && (state != IDLE);
      // Nonblocking write keeps a same-edge accept on the pre-write constant.
      if (cfg_we && state == IDLE) const_tbl[cfg_addr] <= cfg_data;
      if (accept) begin
        op_sh  <= PAD_W'(a_in);
        cst_sh <= PAD_W'(const_tbl[idx]);
        carry  <= 1'b0;
        cnt    <= '0;
      end else if (state == RUN) begin
        op_sh  <= op_next;
        cst_sh <= cst_sh >> LIMB_W;
        carry  <= limb_sum[LIMB_W];
        cnt    <= cnt + CNT_W'(1);
        if (cnt == LAST_LIMB) begin
          sum_out   <= op_next[WIDTH-1:0];
          carry_out <= limb_sum[TOP_W];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_corr_add_serial_unit.sv
// Scoreboard bench for corr_add_serial_unit: shadow table model, queued expectations.
`default_nettype none

module tb_corr_add_serial_unit;

  localparam int W  = 1506;
  localparam int IW = 4;
  localparam int NL = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [IW-1:0] cfg_addr = '0;
  logic [W-1:0]  cfg_data = '0;
  logic          cfg_err;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a_in = '0;
  logic [IW-1:0] idx = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  sum_out;
  logic          carry_out;

  corr_add_serial_unit #(.WIDTH(W), .IDX_W(IW), .LIMB_W(128)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_err(cfg_err), .in_valid(in_valid),
    .in_ready(in_ready), .a_in(a_in), .idx(idx), .out_valid(out_valid),
    .out_ready(out_ready), .sum_out(sum_out), .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  int           n_total = 0;
  int           n_bad   = 0;
  int           cyc     = 0;
  int           acc_cyc = 0;
  logic         prev_ov = 1'b0;
  logic [W-1:0] mdl [16];
  logic [W:0]   sb_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [W:0] got, input logic [W:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Results are compared on the negedge before the handshake edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && !prev_ov)
      check_val("latency", (W+1)'(cyc - acc_cyc), (W+1)'(NL));
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) check_val("unexpected_out", 1, 0);
      else check_val("result", {carry_out, sum_out}, sb_q.pop_front());
    end
    prev_ov = rst_n && out_valid;
  end

  task automatic wait_ready();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) return;
    end
    check_val("ready_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (sb_q.size() == 0) return;
      @(negedge clk);
    end
    check_val("drain_timeout", (W+1)'(sb_q.size()), 0);
    sb_q.delete();
  endtask

  task automatic send(input logic [W-1:0] a, input logic [IW-1:0] i);
    wait_ready();
    in_valid = 1'b1; a_in = a; idx = i;
    sb_q.push_back({1'b0, a} + {1'b0, mdl[i]});
    @(posedge clk); #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wcfg(input logic [IW-1:0] ad, input logic [W-1:0] d, input logic ok);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = ad; cfg_data = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    if (ok) mdl[ad] = d;
    @(negedge clk);
    check_val("cfg_err", (W+1)'(cfg_err), (W+1)'(!ok));
    if (!ok) begin
      @(negedge clk);
      check_val("cfg_err_once", (W+1)'(cfg_err), 0);
    end
  endtask

  function automatic logic [W-1:0] rnd_wide();
    logic [1535:0] t;
    for (int k = 0; k < 48; k++) t[32*k +: 32] = $urandom;
    return t[W-1:0];
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] one, hold_s, x2, y2, ra;
    logic         hold_c;
    one = W'(1);
    for (int e = 0; e < 16; e++) mdl[e] = '0;

    #23;
    check_val("rst_in_ready", (W+1)'(in_ready), 0);
    check_val("rst_out_valid", (W+1)'(out_valid), 0);
    check_val("rst_sum", {carry_out, sum_out}, 0);
    check_val("rst_cfg_err", (W+1)'(cfg_err), 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check_val("ready_after_rst", (W+1)'(in_ready), 1);

    // Wrap and carry
    wcfg(1, one << 1505, 1'b1);
    send(one << 1505, 1); drain();
    // Carry rippling across eight limb boundaries
    wcfg(3, one, 1'b1);
    send((one << 1024) - one, 3); drain();
    // Top-limb masking
    wcfg(15, '1, 1'b1);
    send(one, 15); drain();
    send('0, 15); drain();
    // Entry 0 is loadable
    wcfg(0, one << 700, 1'b1);
    send(one << 700, 0); drain();

    // Backpressure in DONE
    @(posedge clk); #1 out_ready = 1'b0;
    send(12345, 3);
    for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
    check_val("bp_valid", (W+1)'(out_valid), 1);
    hold_s = sum_out; hold_c = carry_out;
    in_valid = 1'b1; a_in = 999; idx = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("bp_stable", {carry_out, sum_out}, {hold_c, hold_s});
      check_val("bp_in_ready", (W+1)'(in_ready), 0);
      check_val("bp_valid_held", (W+1)'(out_valid), 1);
    end
    in_valid = 1'b0;
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("bp_ready_after", (W+1)'(in_ready), 1);
    check_val("bp_valid_drop", (W+1)'(out_valid), 0);
    check_val("bp_queue", (W+1)'(sb_q.size()), 0);

    // Busy write rejection
    x2 = (W'(12345) << 600) | W'(77);
    y2 = one << 1500;
    wcfg(2, x2, 1'b1);
    send(5, 2);
    repeat (2) @(posedge clk);
    wcfg(2, y2, 1'b0);
    drain();
    send('0, 2); drain();
    // Same-edge write and accept: op sees the old constant
    wait_ready();
    cfg_we = 1'b1; cfg_addr = 2; cfg_data = y2;
    in_valid = 1'b1; a_in = 3; idx = 2;
    sb_q.push_back({1'b0, W'(3)} + {1'b0, mdl[2]});
    @(posedge clk); #1;
    acc_cyc = cyc;
    cfg_we = 1'b0; in_valid = 1'b0; mdl[2] = y2;
    @(negedge clk);
    check_val("same_edge_no_err", (W+1)'(cfg_err), 0);
    drain();
    send('0, 2); drain();

    // Random loads and operands
    for (int n = 0; n < 4; n++) begin
      wcfg(IW'(n + 4), rnd_wide(), 1'b1);
      ra = rnd_wide();
      send(ra, IW'(n + 4)); drain();
    end

    // Reset mid-RUN
    wcfg(9, one << 3, 1'b1);
    send(100, 9);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("midrst_valid", (W+1)'(out_valid), 0);
    check_val("midrst_ready", (W+1)'(in_ready), 0);
    sb_q.delete();
    for (int e = 0; e < 16; e++) mdl[e] = '0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check_val("midrst_ready_after", (W+1)'(in_ready), 1);
    send(7, 9); drain();
    send(1, 15); drain();

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
